id_stage: RTL and testbench

//  RV32I instruction-decode stage; sits between the IF/ID register and the EX stage.

---
 rtl/rv32i_pkg.sv | 85 ++++++++
 rtl/imm_gen.sv | 34 +++
 rtl/id_stage.sv | 187 ++++++++++++++++++
 tb/tb_id_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// RV32I shared decode definitions: opcodes, ALU codes, EX_CTRL bit
// indices, funct3/funct7 names and the ID/EX pipeline bundle.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam int C_JALR     = 9;
    localparam int C_JAL      = 8;
    localparam int C_BRANCH   = 7;
    localparam int C_MEMWR    = 6;
    localparam int C_MEMRD    = 5;
    localparam int C_REGWR    = 4;
    localparam int C_SRCA_PC  = 3;
    localparam int C_SRCB_IMM = 2;
    localparam int C_LUI      = 1;
    localparam int C_AUIPC    = 0;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1val;
        logic [31:0] rs2val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  aluop;
        logic [9:0]  ctrl;
        logic [2:0]  funct3;
        logic        illegal;
    } id_ex_t;

    function automatic logic [3:0] alu_sel(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [3:0] op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator: instr -> sign-extended I/S/B/U/J immediate.
// Ports: instr (in, 32), imm (out, 32); purely combinational.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    logic [6:0] op;
    logic       s;

    assign op = instr[6:0];
    assign s  = instr[31];

    always_comb begin
        imm = {{20{s}}, instr[31:20]};
        unique case (1'b1)
            (op == OP_STORE):
                imm = {{20{s}}, instr[31:25], instr[11:7]};
            (op == OP_BRANCH):
                imm = {{19{s}}, s, instr[7],
                       instr[30:25], instr[11:8], 1'b0};
            (op == OP_LUI),
            (op == OP_AUIPC):
                imm = {instr[31:12], 12'b0};
            (op == OP_JAL):
                imm = {{11{s}}, s, instr[19:12],
                       instr[20], instr[30:21], 1'b0};
            default: ;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes IF/ID, reads regfile, detects load-use, fills ID/EX.
// Ports: clk/rst, if_* in, flush in, rnum*/rdata* regfile, stall out, ex_* ID/EX out.
module id_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_instr,
    input  logic            flush,
    output logic [4:0]      rnum1,
    output logic [4:0]      rnum2,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1val,
    output logic [XLEN-1:0] ex_rs2val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_aluop,
    output logic [9:0]      ex_ctrl,
    output logic [2:0]      ex_funct3,
    output logic            ex_illegal
);

    logic [6:0]  opcode;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [9:0]  ctrl;
    logic [3:0]  alu;
    logic        rs1_used;
    logic        rs2_used;
    logic        illegal;
    logic        haz;
    logic        kill;
    logic        ill_issue;
    id_ex_t      ex;
    id_ex_t      id_d;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign f3     = if_instr[14:12];
    assign rnum1  = if_instr[19:15];
    assign rnum2  = if_instr[24:20];
    assign f7     = if_instr[31:25];

    imm_gen u_imm (
        .instr (if_instr),
        .imm   (imm)
    );

    always_comb begin
        ctrl     = '0;
        alu      = ALU_ADD;
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        illegal  = 1'b0;
        unique case (1'b1)
            (opcode == OP_LUI): begin
                ctrl[C_REGWR]    = 1'b1;
                ctrl[C_SRCB_IMM] = 1'b1;
                ctrl[C_LUI]      = 1'b1;
                alu              = ALU_PASSB;
                rs1_used         = 1'b0;
            end
            (opcode == OP_AUIPC): begin
                ctrl[C_REGWR]    = 1'b1;
                ctrl[C_SRCA_PC]  = 1'b1;
                ctrl[C_SRCB_IMM] = 1'b1;
                ctrl[C_AUIPC]    = 1'b1;
                rs1_used         = 1'b0;
            end
            (opcode == OP_JAL): begin
                ctrl[C_JAL]      = 1'b1;
                ctrl[C_REGWR]    = 1'b1;
                ctrl[C_SRCA_PC]  = 1'b1;
                ctrl[C_SRCB_IMM] = 1'b1;
                rs1_used         = 1'b0;
            end
            (opcode == OP_JALR): begin
                ctrl[C_JALR]     = 1'b1;
                ctrl[C_REGWR]    = 1'b1;
                ctrl[C_SRCB_IMM] = 1'b1;
            end
            (opcode == OP_BRANCH): begin
                ctrl[C_BRANCH] = 1'b1;
                alu            = ALU_SUB;
                rs2_used       = 1'b1;
            end
            (opcode == OP_LOAD): begin
                ctrl[C_MEMRD]    = 1'b1;
                ctrl[C_REGWR]    = 1'b1;
                ctrl[C_SRCB_IMM] = 1'b1;
            end
            (opcode == OP_STORE): begin
                ctrl[C_MEMWR]    = 1'b1;
                ctrl[C_SRCB_IMM] = 1'b1;
                rs2_used         = 1'b1;
            end
            (opcode == OP_OPIMM): begin
                ctrl[C_REGWR]    = 1'b1;
                ctrl[C_SRCB_IMM] = 1'b1;
                // only the shift-right form may select the alternate op
                alu = alu_sel(f3, (f3 == F3_SR) & f7[5]);
                illegal = ((f3 == F3_SLL) & (f7 != F7_BASE)) |
                          ((f3 == F3_SR) & (f7 != F7_BASE) &
                           (f7 != F7_ALT));
            end
            (opcode == OP_OP): begin
                ctrl[C_REGWR] = 1'b1;
                rs2_used      = 1'b1;
                alu           = alu_sel(f3, f7[5]);
                illegal = !((f7 == F7_BASE) ||
                            ((f7 == F7_ALT) &&
                             ((f3 == F3_ADD) || (f3 == F3_SR))));
            end
            (opcode == OP_MISC),
            (opcode == OP_SYSTEM): ;
            default: illegal = 1'b1;
        endcase
        if (illegal || rd == 5'd0) ctrl[C_REGWR] = 1'b0;
        if (illegal) ctrl = '0;
    end

    always_comb begin
        id_d         = '0;
        id_d.valid   = 1'b1;
        id_d.pc      = if_pc;
        id_d.rs1val  = rdata1;
        id_d.rs2val  = rdata2;
        id_d.imm     = imm;
        id_d.rs1     = rnum1;
        id_d.rs2     = rnum2;
        id_d.rd      = ctrl[C_REGWR] ? rd : 5'd0;
        id_d.aluop   = alu;
        id_d.ctrl    = ctrl;
        id_d.funct3  = f3;
        id_d.illegal = 1'b0;
    end

    assign haz = ex.valid & ex.ctrl[C_MEMRD] &
                 (ex.rd != 5'd0) & if_valid &
                 ((rs1_used & (rnum1 == ex.rd)) |
                  (rs2_used & (rnum2 == ex.rd)));

    assign stall     = haz & ~flush & ~rst;
    assign kill      = flush | haz | ~if_valid;
    assign ill_issue = illegal & ILLEGAL_AS_NOP;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex <= '0;
        end else if (kill || ill_issue) begin
            // bubble: control only, data fields keep stale values
            ex.valid   <= 1'b0;
            ex.ctrl    <= '0;
            ex.rd      <= '0;
            ex.illegal <= !kill && ill_issue;
        end else begin
            ex <= id_d;
        end
    end

    assign ex_valid   = ex.valid;
    assign ex_pc      = ex.pc;
    assign ex_rs1val  = ex.rs1val;
    assign ex_rs2val  = ex.rs2val;
    assign ex_imm     = ex.imm;
    assign ex_rs1     = ex.rs1;
    assign ex_rs2     = ex.rs2;
    assign ex_rd      = ex.rd;
    assign ex_aluop   = ex.aluop;
    assign ex_ctrl    = ex.ctrl;
    assign ex_funct3  = ex.funct3;
    assign ex_illegal = ex.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed spec scenarios, then random instruction
// streams checked against a mnemonic-level reference model.
module tb_id_stage;

    localparam logic [9:0] B_JALR  = 10'b10_0000_0000;
    localparam logic [9:0] B_JAL   = 10'b01_0000_0000;
    localparam logic [9:0] B_BR    = 10'b00_1000_0000;
    localparam logic [9:0] B_MEMWR = 10'b00_0100_0000;
    localparam logic [9:0] B_MEMRD = 10'b00_0010_0000;
    localparam logic [9:0] B_REGWR = 10'b00_0001_0000;
    localparam logic [9:0] B_SRCA  = 10'b00_0000_1000;
    localparam logic [9:0] B_SRCB  = 10'b00_0000_0100;
    localparam logic [9:0] B_LUI   = 10'b00_0000_0010;
    localparam logic [9:0] B_AUIPC = 10'b00_0000_0001;

    typedef struct {
        logic        ill;
        logic [9:0]  ctrl;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic        u1;
        logic        u2;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_instr = '0;
    logic        flush = 1'b0;
    logic [4:0]  rnum1, rnum2;
    logic [31:0] rdata1 = '0;
    logic [31:0] rdata2 = '0;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1val, ex_rs2val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_aluop;
    logic [9:0]  ex_ctrl;
    logic [2:0]  ex_funct3;
    logic        ex_illegal;

    int total = 0;
    int bad   = 0;

    // reference EX state
    logic        m_valid = 0, m_ill = 0, m_all = 0;
    logic [9:0]  m_ctrl = 0;
    logic [4:0]  m_rd = 0, m_rs1 = 0, m_rs2 = 0;
    logic [31:0] m_pc = 0, m_v1 = 0, m_v2 = 0, m_imm = 0;
    logic [3:0]  m_alu = 0;
    logic [2:0]  m_f3 = 0;
    logic        obs_stall;
    logic [4:0]  obs_rnum1;

    id_stage dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .flush      (flush),
        .rnum1      (rnum1),
        .rnum2      (rnum2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .ex_pc      (ex_pc),
        .ex_rs1val  (ex_rs1val),
        .ex_rs2val  (ex_rs2val),
        .ex_imm     (ex_imm),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_rd      (ex_rd),
        .ex_aluop   (ex_aluop),
        .ex_ctrl    (ex_ctrl),
        .ex_funct3  (ex_funct3),
        .ex_illegal (ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic dec_t ref_dec(input logic [31:0] w);
        int tab[8];
        logic [31:0] sx;
        logic [6:0]  f7;
        logic [2:0]  f3;
        dec_t d;
        tab = '{0, 2, 3, 4, 5, 6, 8, 9};
        sx = w[31] ? 32'hFFFF_FFFF : 32'h0;
        f7 = w[31:25];
        f3 = w[14:12];
        d.ill = 0; d.ctrl = 0; d.alu = 0; d.u1 = 1; d.u2 = 0;
        d.imm = 32'($signed(w) >>> 20);
        case (w[6:0])
            7'h37: begin
                d.ctrl = B_REGWR | B_SRCB | B_LUI;
                d.alu = 10; d.u1 = 0; d.imm = w & 32'hFFFF_F000;
            end
            7'h17: begin
                d.ctrl = B_REGWR | B_SRCA | B_SRCB | B_AUIPC;
                d.u1 = 0; d.imm = w & 32'hFFFF_F000;
            end
            7'h6F: begin
                d.ctrl = B_JAL | B_REGWR | B_SRCA | B_SRCB;
                d.u1 = 0;
                d.imm = (sx << 20) | (32'(w[19:12]) << 12) |
                        (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            end
            7'h67: d.ctrl = B_JALR | B_REGWR | B_SRCB;
            7'h63: begin
                d.ctrl = B_BR; d.alu = 1; d.u2 = 1;
                d.imm = (sx << 12) | (32'(w[7]) << 11) |
                        (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            end
            7'h03: d.ctrl = B_MEMRD | B_REGWR | B_SRCB;
            7'h23: begin
                d.ctrl = B_MEMWR | B_SRCB; d.u2 = 1;
                d.imm = (d.imm & 32'hFFFF_FFE0) | 32'(w[11:7]);
            end
            7'h13: begin
                d.ctrl = B_REGWR | B_SRCB;
                d.alu = 4'(tab[f3]);
                if (f3 == 5 && w[30]) d.alu = 7;
                if (f3 == 1 && f7 != 0) d.ill = 1;
                if (f3 == 5 && f7 != 0 && f7 != 7'h20) d.ill = 1;
            end
            7'h33: begin
                d.ctrl = B_REGWR; d.u2 = 1;
                if (f7 == 0) d.alu = 4'(tab[f3]);
                else if (f7 == 7'h20 && f3 == 0) d.alu = 1;
                else if (f7 == 7'h20 && f3 == 5) d.alu = 7;
                else d.ill = 1;
            end
            7'h0F, 7'h73: ;
            default: d.ill = 1;
        endcase
        if (w[11:7] == 0) d.ctrl &= ~B_REGWR;
        if (d.ill) d.ctrl = 0;
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[12];
        logic [6:0] f7s[3];
        logic [31:0] w;
        int k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h03};
        f7s = '{7'h00, 7'h20, 7'h01};
        w = $urandom;
        k = $urandom_range(12);
        w[6:0] = (k == 12) ? 7'($urandom) : ops[k];
        w[11:7]  = 5'($urandom_range(3));
        w[19:15] = 5'($urandom_range(3));
        w[24:20] = 5'($urandom_range(3));
        if (w[6:0] == 7'h33 ||
            (w[6:0] == 7'h13 && w[13:12] == 2'b01))
            w[31:25] = f7s[$urandom_range(2)];
        return w;
    endfunction

    task automatic step(input logic r, input logic v,
                        input logic [31:0] w, input logic fl);
        dec_t d;
        logic haz, es;
        logic [31:0] pc, d1, d2;
        @(negedge clk);
        pc = $urandom & 32'hFFFF_FFFC;
        d1 = $urandom;
        d2 = $urandom;
        rst = r; if_valid = v; if_instr = w; if_pc = pc;
        flush = fl; rdata1 = d1; rdata2 = d2;
        #1;
        d = ref_dec(w);
        haz = m_valid && m_ctrl[5] && m_rd != 0 && v &&
              ((d.u1 && w[19:15] == m_rd) ||
               (d.u2 && w[24:20] == m_rd));
        es = !r && !fl && haz;
        obs_stall = stall;
        obs_rnum1 = rnum1;
        chk("stall", 32'(stall), 32'(es));
        chk("rnum1", 32'(rnum1), 32'(w[19:15]));
        chk("rnum2", 32'(rnum2), 32'(w[24:20]));
        @(posedge clk);
        m_all = r;
        if (r) begin
            m_valid = 0; m_ill = 0; m_ctrl = 0; m_rd = 0;
            m_pc = 0; m_v1 = 0; m_v2 = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_alu = 0; m_f3 = 0;
        end else if (fl || haz || !v || d.ill) begin
            m_valid = 0; m_ctrl = 0; m_rd = 0;
            m_ill = !(fl || haz || !v) && d.ill;
        end else begin
            m_valid = 1; m_ill = 0; m_ctrl = d.ctrl;
            m_rd = d.ctrl[4] ? w[11:7] : 5'd0;
            m_pc = pc; m_v1 = d1; m_v2 = d2; m_imm = d.imm;
            m_rs1 = w[19:15]; m_rs2 = w[24:20];
            m_alu = d.alu; m_f3 = w[14:12];
        end
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
        chk("ex_rd", 32'(ex_rd), 32'(m_rd));
        chk("ex_illegal", 32'(ex_illegal), 32'(m_ill));
        if (m_valid || m_all) begin
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_rs1val", ex_rs1val, m_v1);
            chk("ex_rs2val", ex_rs2val, m_v2);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_rs1", 32'(ex_rs1), 32'(m_rs1));
            chk("ex_rs2", 32'(ex_rs2), 32'(m_rs2));
            chk("ex_aluop", 32'(ex_aluop), 32'(m_alu));
            chk("ex_funct3", 32'(ex_funct3), 32'(m_f3));
        end
    endtask

    initial begin
        logic [31:0] cur;
        logic fl, v;
        // reset with a valid instruction present
        step(1, 1, 32'hFFF0_0293, 0);
        step(1, 1, 32'hFFF0_0293, 0);
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_imm", ex_imm, 0);
        chk("rst_stall", 32'(obs_stall), 0);
        // ADDI x5,x0,-1
        step(0, 1, 32'hFFF0_0293, 0);
        chk("addi_valid", 32'(ex_valid), 1);
        chk("addi_imm", ex_imm, 32'hFFFF_FFFF);
        chk("addi_alu", 32'(ex_aluop), 0);
        chk("addi_regwr", 32'(ex_ctrl[4]), 1);
        chk("addi_srcb", 32'(ex_ctrl[2]), 1);
        chk("addi_rd", 32'(ex_rd), 5);
        // LW x6 then ADD x7,x6,x2
        step(0, 1, 32'h0000_A303, 0);
        step(0, 1, 32'h0023_03B3, 0);
        chk("lu_stall", 32'(obs_stall), 1);
        chk("lu_bubble", 32'(ex_valid), 0);
        step(0, 1, 32'h0023_03B3, 0);
        chk("lu_stall2", 32'(obs_stall), 0);
        chk("lu_rnum1", 32'(obs_rnum1), 6);
        chk("lu_issue", 32'(ex_valid), 1);
        chk("lu_rs1", 32'(ex_rs1), 6);
        // LW x0 then ADD x7,x0,x2; LW x6 then LUI x6
        step(0, 1, 32'h0000_A003, 0);
        step(0, 1, 32'h0020_03B3, 0);
        chk("x0_nostall", 32'(obs_stall), 0);
        step(0, 1, 32'h0000_A303, 0);
        step(0, 1, 32'h1234_5337, 0);
        chk("lui_nostall", 32'(obs_stall), 0);
        // FLUSH during a load-use hazard
        step(0, 1, 32'h0000_A303, 0);
        step(0, 1, 32'h0023_03B3, 1);
        chk("fl_stall", 32'(obs_stall), 0);
        chk("fl_valid", 32'(ex_valid), 0);
        // BEQ x1,x2,-4
        step(0, 1, 32'hFE20_8EE3, 0);
        chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
        chk("beq_br", 32'(ex_ctrl[7]), 1);
        // illegal opcode, illegal funct7, SRA/SRL
        step(0, 1, 32'h0000_007F, 0);
        chk("ill_valid", 32'(ex_valid), 0);
        chk("ill_flag", 32'(ex_illegal), 1);
        step(0, 1, 32'h0000_0013, 0);
        chk("ill_pulse", 32'(ex_illegal), 0);
        step(0, 1, 32'h0220_81B3, 0);
        chk("mul_ill", 32'(ex_illegal), 1);
        chk("mul_valid", 32'(ex_valid), 0);
        step(0, 1, 32'h4020_D1B3, 0);
        chk("sra_alu", 32'(ex_aluop), 7);
        step(0, 1, 32'h0020_D1B3, 0);
        chk("srl_alu", 32'(ex_aluop), 6);
        // random stream; IF holds the instruction while stalled
        cur = rand_instr();
        for (int i = 0; i < 800; i++) begin
            fl = ($urandom_range(15) == 0);
            v  = ($urandom_range(7) != 0);
            step(0, v, cur, fl);
            if (!obs_stall) cur = rand_instr();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
